// File: rtl/delay_line_pkg.sv
// Shared definitions for the delay-line measurement path.
// Contents: FSM state encodings and the default count width.
package delay_line_pkg;

   localparam int unsigned DEF_CNT_W = 16;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_COUNT = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      COUNT = ST_COUNT,
      HOLD  = ST_HOLD
   } state_t;

endpackage

// File: rtl/sync_rise.sv
// Multi-stage synchroniser for an asynchronous level, plus rising-edge detect.
// Ports:
//   clk  - sampling clock
//   rst  - synchronous active-high reset
//   d    - asynchronous input level
//   rise - one-cycle pulse when the synchronised level goes 0 -> 1
module sync_rise #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_last;

   // Stage 0 takes the async input; the MSB is the first usable level.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '0;
         r_last <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], d};
         r_last <= r_sync[SYNC_STAGES-1];
      end
   end

   assign rise = r_sync[SYNC_STAGES-1] & ~r_last;

endmodule

// File: rtl/echo_timer.sv
// Measures clk cycles from a start rising edge to the returned echo rising
// edge, or reports a timeout, and presents the result on a valid/ready port.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   start             - synchronous trigger; rising edge arms a measurement
//   echo              - asynchronous return pulse; rising edge stops the count
//   busy              - high while counting or holding a result
//   meas/meas_timeout - result count and timeout qualifier
//   meas_valid/ready  - result handshake
//   overrun           - sticky flag for start edges dropped while not idle
module echo_timer
   import delay_line_pkg::*;
#(
   parameter int unsigned CNT_W       = DEF_CNT_W,
   parameter int unsigned TIMEOUT     = 1000,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             echo,
   output logic             busy,
   output logic [CNT_W-1:0] meas,
   output logic             meas_timeout,
   output logic             meas_valid,
   input  logic             meas_ready,
   output logic             overrun
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [CNT_W-1:0] r_meas, w_meas_nxt;
   logic             r_to, w_to_nxt;
   logic             r_overrun, w_overrun_nxt;
   logic             r_busy, r_valid;
   logic             r_start_q;
   logic             w_start_rise;
   logic             w_echo_rise;

   sync_rise #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_echo_sync (
      .clk  (clk),
      .rst  (rst),
      .d    (echo),
      .rise (w_echo_rise)
   );

   assign w_start_rise = start & ~r_start_q;

   // Next-state, counter and result capture.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_meas_nxt    = r_meas;
      w_to_nxt      = r_to;
      w_overrun_nxt = r_overrun;
      case (r_state)
         IDLE: begin
            if (w_start_rise) begin
               w_state_nxt = COUNT;
               w_cnt_nxt   = '0;
            end
         end
         COUNT: begin
            // Echo takes priority over a simultaneous timeout.
            if (w_echo_rise) begin
               w_state_nxt = HOLD;
               w_meas_nxt  = r_cnt;
               w_to_nxt    = 1'b0;
            end else if (r_cnt == LIMIT) begin
               w_state_nxt = HOLD;
               w_meas_nxt  = LIMIT;
               w_to_nxt    = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         HOLD: begin
            if (r_valid && meas_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
      // Any start edge outside IDLE (including the HOLD exit cycle) is dropped.
      if (w_start_rise && (r_state != IDLE)) begin
         w_overrun_nxt = 1'b1;
      end
   end

   // State and registered outputs; busy/valid reflect the state just entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_meas    <= '0;
         r_to      <= 1'b0;
         r_overrun <= 1'b0;
         r_busy    <= 1'b0;
         r_valid   <= 1'b0;
         r_start_q <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_meas    <= w_meas_nxt;
         r_to      <= w_to_nxt;
         r_overrun <= w_overrun_nxt;
         r_busy    <= (w_state_nxt != IDLE);
         r_valid   <= (w_state_nxt == HOLD);
         r_start_q <= start;
      end
   end

   assign busy         = r_busy;
   assign meas         = r_meas;
   assign meas_timeout = r_to;
   assign meas_valid   = r_valid;
   assign overrun      = r_overrun;

endmodule

// File: tb/tb_echo_timer.sv
// Self-checking bench for echo_timer (TIMEOUT=100, SYNC_STAGES=2).
module tb_echo_timer;

   localparam int unsigned CNT_W   = 16;
   localparam int unsigned TMO     = 100;
   localparam int unsigned SYNC    = 2;

   logic             clk;
   logic             rst;
   logic             start;
   logic             echo;
   logic             busy;
   logic [CNT_W-1:0] meas;
   logic             meas_timeout;
   logic             meas_valid;
   logic             meas_ready;
   logic             overrun;

   int checks = 0;
   int errors = 0;

   echo_timer #(
      .CNT_W       (CNT_W),
      .TIMEOUT     (TMO),
      .SYNC_STAGES (SYNC)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .echo         (echo),
      .busy         (busy),
      .meas         (meas),
      .meas_timeout (meas_timeout),
      .meas_valid   (meas_valid),
      .meas_ready   (meas_ready),
      .overrun      (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: echo rising just after P_n is seen n+SYNC-1 counts after the
   // start; if that exceeds TMO the result is a timeout at TMO. Result is
   // visible two cycles after the captured count value.
   function automatic void model(input int n, output int m, output int to);
      if (n >= 1 && (n + int'(SYNC) - 1) <= int'(TMO)) begin
         m  = n + int'(SYNC) - 1;
         to = 0;
      end else begin
         m  = int'(TMO);
         to = 1;
      end
   endfunction

   // Start pulse just after P0, echo raised just after P_n (n<=0: no edge).
   task automatic run_meas(input int n, input bit rdy, input string tag);
      int found;
      int m;
      int to;
      meas_ready = rdy;
      step();
      start = 1'b1;
      found = -1;
      for (int k = 1; k <= 400 && found < 0; k++) begin
         step();
         if (k == 1) begin
            start = 1'b0;
            chk({tag, "_busy_arm"}, 32'(busy), 32'd1);
         end
         if (meas_valid) found = k;
         else if (k == n) echo = 1'b1;
      end
      model(n, m, to);
      chk({tag, "_latency"}, 32'(found), 32'(m + 2));
      chk({tag, "_meas"}, 32'(meas), 32'(m));
      chk({tag, "_timeout"}, 32'(meas_timeout), 32'(to));
      if (rdy) begin
         step();
         chk({tag, "_valid_drop"}, 32'(meas_valid), 32'd0);
         chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
         if (n > 0) begin
            echo = 1'b0;
            repeat (4) step();
         end
      end
   endtask

   initial begin
      logic [CNT_W-1:0] held_meas;
      int n;
      rst        = 1'b1;
      start      = 1'b0;
      echo       = 1'b0;
      meas_ready = 1'b1;
      repeat (3) step();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_meas", 32'(meas), 32'd0);
      chk("rst_timeout", 32'(meas_timeout), 32'd0);
      chk("rst_valid", 32'(meas_valid), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      rst = 1'b0;
      repeat (2) step();

      run_meas(10, 1'b1, "basic");
      chk("basic_overrun", 32'(overrun), 32'd0);

      run_meas(0, 1'b1, "noecho");

      for (int i = 0; i < 8; i++) begin
         n = int'($urandom_range(1, 110));
         run_meas(n, 1'b1, "rand");
      end

      run_meas(int'(TMO) - 1, 1'b1, "tie");

      // Echo pulses while idle must not produce a result.
      echo = 1'b1;
      repeat (3) step();
      echo = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("idle_echo_valid", 32'(meas_valid), 32'd0);
      end

      // Echo already high when counting starts: no edge, so timeout.
      echo = 1'b1;
      repeat (5) step();
      run_meas(0, 1'b1, "echo_high");
      echo = 1'b0;
      repeat (4) step();
      chk("pre_bp_overrun", 32'(overrun), 32'd0);

      // Backpressure: result held stable, start during HOLD is dropped.
      run_meas(5, 1'b0, "bp");
      echo = 1'b0;
      held_meas = meas;
      for (int i = 0; i < 20; i++) begin
         if (i == 6) start = 1'b1;
         if (i == 8) start = 1'b0;
         step();
         chk("bp_valid", 32'(meas_valid), 32'd1);
         chk("bp_meas", 32'(meas), 32'(held_meas));
      end
      chk("bp_overrun", 32'(overrun), 32'd1);
      chk("bp_meas_val", 32'(held_meas), 32'd6);
      meas_ready = 1'b1;
      step();
      chk("bp_release_valid", 32'(meas_valid), 32'd0);
      chk("bp_release_busy", 32'(busy), 32'd0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_no_restart", 32'(busy), 32'd0);
      end

      // Reset five cycles into a count.
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (4) step();
      chk("mid_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_meas", 32'(meas), 32'd0);
      chk("mrst_timeout", 32'(meas_timeout), 32'd0);
      chk("mrst_valid", 32'(meas_valid), 32'd0);
      chk("mrst_overrun", 32'(overrun), 32'd0);
      repeat (3) step();
      chk("mrst_idle", 32'(busy), 32'd0);
      run_meas(3, 1'b1, "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
